// File: rtl/alpha_unblend_if.sv
// ============================================================
// Module  : alpha_unblend_if
// Purpose : Pixel-in / object-out valid-ready stream bundle for alpha_unblend.
// Rev     : 1.0
// ============================================================
`default_nettype none

interface alpha_unblend_if;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_pixel;
   logic [23:0] in_background;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_object;
   logic [2:0]  out_clip;
   logic        out_last;

   modport master (
      output in_valid, in_pixel, in_background, in_last, out_ready,
      input  in_ready, out_valid, out_object, out_clip, out_last
   );

   modport slave (
      input  in_valid, in_pixel, in_background, in_last, out_ready,
      output in_ready, out_valid, out_object, out_clip, out_last
   );
endinterface

`default_nettype wire

// File: rtl/alpha_unblend.sv
// ============================================================
// Module  : alpha_unblend
// Purpose : Two-stage inverse of the fixed-alpha blender with clip/frame stats.
// Rev     : 1.0
// ============================================================
`default_nettype none

module alpha_unblend #(
   parameter int ALPHA_N = 1,
   parameter int CNT_W   = 16
) (
   input  wire               clk,
   input  wire               reset_n,
   alpha_unblend_if.slave    bus,
   input  wire               clear_stats,
   output logic [CNT_W-1:0]  clip_count,
   output logic [CNT_W-1:0]  frame_count
);

   localparam int             c_SD_W    = 10 + ALPHA_N;
   localparam int             c_O_W     = 11 + ALPHA_N;
   localparam logic [CNT_W-1:0] c_CNT_ONE = 1;

   logic              r_s1_valid;
   logic              r_s1_last;
   logic              r_s2_valid;
   logic [23:0]       r_s2_obj;
   logic [2:0]        r_s2_clip;
   logic              r_s2_last;
   logic [CNT_W-1:0]  r_clip_count;
   logic [CNT_W-1:0]  r_frame_count;

   logic              w_s1_adv;
   logic              w_s2_adv;
   logic              w_in_fire;
   logic              w_out_fire;
   logic [23:0]       w_s2_obj;
   logic [2:0]        w_s2_clip;

   assign w_s2_adv     = !r_s2_valid || bus.out_ready;
   assign w_s1_adv     = !r_s1_valid || w_s2_adv;
   assign w_in_fire    = bus.in_valid && w_s1_adv;
   assign w_out_fire   = r_s2_valid && bus.out_ready;

   assign bus.in_ready   = w_s1_adv;
   assign bus.out_valid  = r_s2_valid;
   assign bus.out_object = r_s2_obj;
   assign bus.out_clip   = r_s2_clip;
   assign bus.out_last   = r_s2_last;
   assign clip_count     = r_clip_count;
   assign frame_count    = r_frame_count;

   for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      logic [7:0]               w_p;
      logic [7:0]               w_b;
      logic signed [8:0]        w_d;
      logic signed [c_SD_W-1:0] w_sd;
      logic signed [c_SD_W-1:0] r_sd;
      logic [7:0]               r_bg;
      logic signed [c_O_W-1:0]  w_o;
      logic [7:0]               w_obj_ch;
      logic                     w_clip_ch;

      assign w_p  = bus.in_pixel[gi*8 +: 8];
      assign w_b  = bus.in_background[gi*8 +: 8];
      assign w_d  = $signed({1'b0, w_p}) - $signed({1'b0, w_b});
      assign w_sd = $signed({{(c_SD_W-9){w_d[8]}}, w_d}) <<< ALPHA_N;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_sd <= '0;
            r_bg <= '0;
         end else if (w_in_fire) begin
            r_sd <= w_sd;
            r_bg <= w_b;
         end
      end

      // Background is zero-extended, scaled difference sign-extended.
      assign w_o = $signed({{(c_O_W-8){1'b0}}, r_bg})
                 + $signed({{(c_O_W-c_SD_W){r_sd[c_SD_W-1]}}, r_sd});

      always_comb begin
         w_obj_ch  = w_o[7:0];
         w_clip_ch = 1'b0;
         if (w_o[c_O_W-1]) begin
            w_obj_ch  = 8'h00;
            w_clip_ch = 1'b1;
         end else if (|w_o[c_O_W-2:8]) begin
            w_obj_ch  = 8'hFF;
            w_clip_ch = 1'b1;
         end
      end

      assign w_s2_obj[gi*8 +: 8] = w_obj_ch;
      assign w_s2_clip[gi]       = w_clip_ch;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2_obj   <= '0;
         r_s2_clip  <= '0;
         r_s2_last  <= 1'b0;
      end else begin
         if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (w_in_fire) begin
               r_s1_last <= bus.in_last;
            end
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_obj  <= w_s2_obj;
               r_s2_clip <= w_s2_clip;
               r_s2_last <= r_s1_last;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_clip_count  <= '0;
         r_frame_count <= '0;
      end else if (clear_stats) begin
         r_clip_count  <= '0;
         r_frame_count <= '0;
      end else begin
         if (w_out_fire && (|r_s2_clip) && !(&r_clip_count)) begin
            r_clip_count <= r_clip_count + c_CNT_ONE;
         end
         if (w_out_fire && r_s2_last) begin
            r_frame_count <= r_frame_count + c_CNT_ONE;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alpha_unblend.sv
// ============================================================
// Module  : tb_alpha_unblend
// Purpose : Directed self-checking bench for alpha_unblend (ALPHA_N=1, CNT_W=4).
// Rev     : 1.0
// ============================================================
`default_nettype none

module tb_alpha_unblend;

   localparam int c_N = 1;
   localparam int c_W = 4;

   logic            clk;
   logic            reset_n;
   logic            clear_stats;
   logic [c_W-1:0]  clip_count;
   logic [c_W-1:0]  frame_count;

   int n_checks;
   int n_fail;

   logic [23:0] vp [32];
   logic [23:0] vb [32];
   logic        vl [32];

   alpha_unblend_if bus ();

   alpha_unblend #(.ALPHA_N(c_N), .CNT_W(c_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .clear_stats (clear_stats),
      .clip_count  (clip_count),
      .frame_count (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns {clip[2:0], object[23:0]} using o = b + (p-b)*2^N with clamping.
   function automatic logic [26:0] model(input logic [23:0] p, input logic [23:0] b);
      logic [26:0] r;
      r = '0;
      for (int c = 0; c < 3; c++) begin
         int pv;
         int bv;
         int o;
         pv = int'(p[c*8 +: 8]);
         bv = int'(b[c*8 +: 8]);
         o  = bv + (pv - bv) * (1 << c_N);
         if (o < 0) begin
            r[c*8 +: 8] = 8'h00;
            r[24+c]     = 1'b1;
         end else if (o > 255) begin
            r[c*8 +: 8] = 8'hFF;
            r[24+c]     = 1'b1;
         end else begin
            r[c*8 +: 8] = o[7:0];
         end
      end
      return r;
   endfunction

   task automatic run_stream(input string tag, input int n, input logic [31:0] pat);
      int          tx;
      int          rx;
      int          occ;
      int          cyc;
      logic [26:0] e;
      logic        rdy;
      logic        ifire;
      logic        ofire;
      tx = 0; rx = 0; occ = 0; cyc = 0;
      while (rx < n && cyc < 300) begin
         rdy             = pat[cyc % 32];
         bus.out_ready   = rdy;
         bus.in_valid    = (tx < n);
         if (tx < n) begin
            bus.in_pixel      = vp[tx];
            bus.in_background = vb[tx];
            bus.in_last       = vl[tx];
         end
         #1;
         chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(!(occ == 2 && !rdy)));
         if (bus.out_valid) begin
            e = model(vp[rx], vb[rx]);
            chk({tag, "_obj"},  32'(bus.out_object), 32'(e[23:0]));
            chk({tag, "_clip"}, 32'(bus.out_clip),   32'(e[26:24]));
            chk({tag, "_last"}, 32'(bus.out_last),   32'(vl[rx]));
         end
         ifire = bus.in_valid && bus.in_ready;
         ofire = bus.out_valid && rdy;
         if (ifire) tx++;
         if (ofire) rx++;
         occ = occ + int'(ifire) - int'(ofire);
         cyc++;
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk({tag, "_beats"}, 32'(rx), 32'(n));
      #1;
      chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      n_checks          = 0;
      n_fail            = 0;
      reset_n           = 1'b0;
      clear_stats       = 1'b0;
      bus.in_valid      = 1'b0;
      bus.in_pixel      = '0;
      bus.in_background = '0;
      bus.in_last       = 1'b0;
      bus.out_ready     = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_out_valid", 32'(bus.out_valid),  32'd0);
      chk("rst_out_object", 32'(bus.out_object), 32'd0);
      chk("rst_out_clip",  32'(bus.out_clip),   32'd0);
      chk("rst_out_last",  32'(bus.out_last),   32'd0);
      chk("rst_clip_cnt",  32'(clip_count),     32'd0);
      chk("rst_frame_cnt", 32'(frame_count),    32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),   32'd1);
      reset_n = 1'b1;
      tick();

      // Basic vector: 2*0x80-0x40=0xC0, 2*0x40-0x20=0x60, 2*0x20-0x10=0x30
      bus.in_valid      = 1'b1;
      bus.in_pixel      = 24'h804020;
      bus.in_background = 24'h402010;
      bus.in_last       = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      chk("t1_not_yet", 32'(bus.out_valid), 32'd0);
      tick();
      chk("t1_valid", 32'(bus.out_valid),  32'd1);
      chk("t1_obj",   32'(bus.out_object), 32'hC06030);
      chk("t1_clip",  32'(bus.out_clip),   32'd0);
      tick();
      chk("t1_gone",  32'(bus.out_valid),  32'd0);

      // Clipping: R=510->FF, G=-255->00, B=0x80
      bus.in_valid      = 1'b1;
      bus.in_pixel      = 24'hFF0080;
      bus.in_background = 24'h00FF80;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("t2_valid",    32'(bus.out_valid),  32'd1);
      chk("t2_obj",      32'(bus.out_object), 32'hFF0080);
      chk("t2_clip",     32'(bus.out_clip),   32'b110);
      chk("t2_cnt_pre",  32'(clip_count),     32'd0);
      tick();
      chk("t2_cnt_post", 32'(clip_count),     32'd1);

      // Eight beats against an irregular out_ready pattern
      vp[0] = 24'h804020; vb[0] = 24'h402010; vl[0] = 1'b0;
      vp[1] = 24'hFF0080; vb[1] = 24'h00FF80; vl[1] = 1'b0;
      vp[2] = 24'h102030; vb[2] = 24'h102030; vl[2] = 1'b0;
      vp[3] = 24'h000000; vb[3] = 24'hFFFFFF; vl[3] = 1'b1;
      vp[4] = 24'h7F8081; vb[4] = 24'h808080; vl[4] = 1'b0;
      vp[5] = 24'h123456; vb[5] = 24'h654321; vl[5] = 1'b0;
      vp[6] = 24'hFFFFFF; vb[6] = 24'h000000; vl[6] = 1'b0;
      vp[7] = 24'h55AA33; vb[7] = 24'hAA5533; vl[7] = 1'b1;
      run_stream("rnd", 8, 32'hC64C_8E32);

      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      chk("clr_clip_cnt",  32'(clip_count),  32'd0);
      chk("clr_frame_cnt", 32'(frame_count), 32'd0);

      // Three frames of four unclipped beats
      for (int i = 0; i < 12; i++) begin
         vp[i] = 24'h204060 + 24'(i);
         vb[i] = 24'h204060 + 24'(i);
         vl[i] = ((i % 4) == 3);
      end
      run_stream("frm", 12, 32'hFFFF_FFFF);
      chk("frm_frame_cnt", 32'(frame_count), 32'd3);
      chk("frm_clip_cnt",  32'(clip_count),  32'd0);

      // Clear coincides with a clipped last beat transferring
      bus.in_valid      = 1'b1;
      bus.in_pixel      = 24'hFF0080;
      bus.in_background = 24'h00FF80;
      bus.in_last       = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("clrx_valid", 32'(bus.out_valid), 32'd1);
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      chk("clrx_clip_cnt",  32'(clip_count),  32'd0);
      chk("clrx_frame_cnt", 32'(frame_count), 32'd0);

      // 17 clipped last beats: clip saturates at 0xF, frames wrap to 1
      for (int i = 0; i < 17; i++) begin
         vp[i] = 24'h00FF10;
         vb[i] = 24'h80_00_10;
         vl[i] = 1'b1;
      end
      run_stream("sat", 17, 32'hFFFF_FFFF);
      chk("sat_clip_cnt",  32'(clip_count),  32'hF);
      chk("sat_frame_cnt", 32'(frame_count), 32'd1);

      // Reset with two beats in flight and output stalled
      bus.out_ready     = 1'b0;
      bus.in_valid      = 1'b1;
      bus.in_pixel      = 24'h111111;
      bus.in_background = 24'h222222;
      bus.in_last       = 1'b1;
      tick();
      bus.in_pixel      = 24'h333333;
      tick();
      bus.in_valid = 1'b0;
      #1;
      chk("inflt_valid",    32'(bus.out_valid), 32'd1);
      chk("inflt_in_ready", 32'(bus.in_ready),  32'd0);
      reset_n = 1'b0;
      #1;
      chk("arst_valid",     32'(bus.out_valid),  32'd0);
      chk("arst_obj",       32'(bus.out_object), 32'd0);
      chk("arst_clip_cnt",  32'(clip_count),     32'd0);
      chk("arst_frame_cnt", 32'(frame_count),    32'd0);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      #2;
      reset_n = 1'b1;
      #1;
      chk("post_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("post_no_ghost", 32'(bus.out_valid), 32'd0);
      bus.out_ready     = 1'b1;
      bus.in_valid      = 1'b1;
      bus.in_pixel      = 24'h804020;
      bus.in_background = 24'h402010;
      bus.in_last       = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      tick();
      chk("post_valid", 32'(bus.out_valid),  32'd1);
      chk("post_obj",   32'(bus.out_object), 32'hC06030);
      tick();
      chk("post_gone",  32'(bus.out_valid),  32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
